trng_word_packer: RTL and testbench

//  Consumer end of the debiaser's bit/valid stream: accepts debiased bits (bit_in qualified
//  by bit_valid), assembles them MSB-first into WORD_W-bit words and buffers completed words
//  in a small FIFO. The FIFO drains over a valid/ready handshake to the TRNG register/bus

---
 rtl/trng_word_packer_pkg.sv | 6 +
 rtl/trng_word_packer_if.sv | 11 +
 rtl/trng_word_packer_sync_fifo.sv | 52 +++++
 rtl/trng_word_packer.sv | 69 ++++++
 tb/tb_trng_word_packer.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/trng_word_packer_pkg.sv
// trng_word_packer_pkg: default sizes and FSM state encoding for the TRNG word packer
package trng_word_packer_pkg;
    localparam int WORD_W_DEF     = 32;
    localparam int FIFO_DEPTH_DEF = 4;
    typedef enum logic {IDLE = 1'b0, COLLECT = 1'b1} state_e;
endpackage

// File: rtl/trng_word_packer_if.sv
// trng_word_packer_if: word stream from packer to bus side
//  word  head-of-FIFO random word (0 when not valid)
//  valid word holds a buffered word
//  ready consumer accepts word when valid & ready
interface trng_word_packer_if #(parameter int W = trng_word_packer_pkg::WORD_W_DEF);
    logic [W-1:0] word;
    logic         valid;
    logic         ready;
    modport master (output word, valid, input ready);
    modport slave  (input word, valid, output ready);
endinterface

// File: rtl/trng_word_packer_sync_fifo.sv
// trng_word_packer_sync_fifo: synchronous first-word-fall-through FIFO
//  clk, rstn        clock, synchronous active-low reset
//  push_i, data_i   write request and data; accepted when not full or popping
//  pop_i            read request; ignored when empty
//  data_o           head entry, 0 when empty
//  full_o, empty_o  status
//  level_o          number of entries held
module trng_word_packer_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pop;
    always_comb begin
        empty_o = level_q == '0;
        full_o  = level_q == LW'(DEPTH);
        do_pop  = pop_i && !empty_o;
        // a full FIFO still takes a push when the head leaves in the same cycle
        do_push = push_i && (!full_o || do_pop);
        level_d = level_q + LW'(do_push) - LW'(do_pop);
        data_o  = empty_o ? '0 : mem_q[rd_q];
        level_o = level_q;
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            wr_q    <= do_push ? wr_q + AW'(1) : wr_q;
            rd_q    <= do_pop ? rd_q + AW'(1) : rd_q;
            level_q <= level_d;
        end
    end
endmodule

// File: rtl/trng_word_packer.sv
// trng_word_packer: packs debiased bits MSB-first into words and buffers them for the bus
//  clk, rstn     clock, synchronous active-low reset
//  enable_i      1 = collect bits, 0 = idle with partial word discarded
//  bit_i         debiased bit, qualified by bit_valid_i
//  clear_ovf_i   pulse clearing the sticky overflow flag
//  word_if       master side of the word stream (word/valid out, ready in)
//  fifo_level_o  words currently buffered
//  overflow_o    sticky: a completed word was dropped
module trng_word_packer
    import trng_word_packer_pkg::*;
#(
    parameter int WORD_W     = WORD_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          enable_i,
    input  logic                          bit_i,
    input  logic                          bit_valid_i,
    input  logic                          clear_ovf_i,
    trng_word_packer_if.master            word_if,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          overflow_o
);
    localparam int CW = $clog2(WORD_W);
    state_e            state_q, state_d;
    logic [WORD_W-1:0] shreg_q, shreg_d, word;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              ovf_q, ovf_d, take, done, keep, full, empty, pop;
    always_comb begin
        take    = state_q == COLLECT && bit_valid_i;
        done    = take && cnt_q == CW'(WORD_W - 1);
        word    = {shreg_q[WORD_W-2:0], bit_i};
        pop     = word_if.valid && word_if.ready;
        keep    = state_q == COLLECT && enable_i;
        state_d = enable_i ? COLLECT : IDLE;
        // leaving COLLECT (or idling) discards any partial word
        shreg_d = keep ? (take ? word : shreg_q) : '0;
        cnt_d   = keep ? (done ? '0 : take ? cnt_q + CW'(1) : cnt_q) : '0;
        // a drop in the same cycle as clear_ovf keeps the flag set
        ovf_d   = (done && full && !pop) || (ovf_q && !clear_ovf_i);
    end
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end
    trng_word_packer_sync_fifo #(.WIDTH(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (done),
        .data_i  (word),
        .pop_i   (pop),
        .data_o  (word_if.word),
        .full_o  (full),
        .empty_o (empty),
        .level_o (fifo_level_o)
    );
    assign word_if.valid = !empty;
    assign overflow_o    = ovf_q;
endmodule

// File: tb/tb_trng_word_packer.sv
// tb_trng_word_packer: randomized and directed bench with a queue-based reference model and scoreboard
module tb_trng_word_packer;
    localparam int W = 32;
    localparam int D = 4;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       enable = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       clear_ovf = 1'b0;
    logic [2:0] fifo_level;
    logic       overflow;
    trng_word_packer_if #(.W(W)) wif ();
    trng_word_packer dut (
        .clk          (clk),
        .rstn         (rstn),
        .enable_i     (enable),
        .bit_i        (bit_in),
        .bit_valid_i  (bit_valid),
        .clear_ovf_i  (clear_ovf),
        .word_if      (wif.master),
        .fifo_level_o (fifo_level),
        .overflow_o   (overflow)
    );
    always #5 clk = ~clk;
    int         checks = 0;
    int         errors = 0;
    bit         mon_on = 1'b0;
    logic [W-1:0] exp_q [$];
    bit         bits_q [$];
    int         m_level = 0;
    bit         m_ovf = 1'b0;
    bit         m_col = 1'b0;
    function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endfunction
    // reference: bits accumulate in a list; a full list becomes a word offered to a bounded buffer
    function automatic void model_edge(bit rn, bit en, bit b, bit bv, bit rdy, bit clr);
        logic [W-1:0] w;
        bit pop, push, drop;
        if (!rn) begin
            m_level = 0;
            m_ovf = 1'b0;
            m_col = 1'b0;
            bits_q.delete();
            exp_q.delete();
            return;
        end
        push = 1'b0;
        drop = 1'b0;
        pop = rdy && m_level > 0;
        if (m_col && bv) begin
            bits_q.push_back(b);
            if (bits_q.size() == W) begin
                w = '0;
                foreach (bits_q[i]) w = {w[W-2:0], bits_q[i]};
                bits_q.delete();
                if (m_level - int'(pop) < D) begin
                    push = 1'b1;
                    exp_q.push_back(w);
                end else drop = 1'b1;
            end
        end
        if (!en) bits_q.delete();
        m_col = en;
        m_level = m_level + int'(push) - int'(pop);
        m_ovf = drop || (m_ovf && !clr);
    endfunction
    task automatic step(input bit rn, input bit en, input bit b, input bit bv, input bit rdy, input bit clr);
        rstn = rn;
        enable = en;
        bit_in = b;
        bit_valid = bv;
        wif.ready = rdy;
        clear_ovf = clr;
        @(posedge clk);
        model_edge(rn, en, b, bv, rdy, clr);
        #1;
    endtask
    task automatic send_bits(input logic [W-1:0] w, input int nbits, input int gap_pct,
                             input bit rdy, input bit rdy_last, input bit clr_last);
        for (int i = W - 1; i >= W - nbits; i--) begin
            while (int'($urandom_range(0, 99)) < gap_pct)
                step(1, 1, 1'($urandom_range(0, 1)), 0, rdy, 0);
            step(1, 1, w[i], 1, i == W - nbits ? rdy_last : rdy, i == W - nbits ? clr_last : 1'b0);
        end
    endtask
    task automatic idle(input int n, input bit en, input bit rdy);
        for (int i = 0; i < n; i++) step(1, en, 0, 0, rdy, 0);
    endtask
    always @(negedge clk) begin
        if (mon_on) begin
            check("fifo_level", 32'(fifo_level), 32'(m_level));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("word_valid", 32'(wif.valid), 32'(m_level > 0));
            if (wif.valid && wif.ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL word_pop: got %h expected no word at %0t", wif.word, $time);
                end else check("word_out", wif.word, exp_q.pop_front());
            end else if (!wif.valid) check("word_out_empty", wif.word, 32'h0);
        end
    end
    initial begin
        wif.ready = 1'b0;
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        mon_on = 1'b1;
        // single word, continuous bits
        idle(1, 1, 1);
        send_bits(32'hA5A5F00F, 32, 0, 1, 1, 0);
        idle(3, 1, 1);
        // same word with gaps and toggling bit_in
        send_bits(32'hA5A5F00F, 32, 40, 1, 1, 0);
        idle(3, 1, 1);
        // five words with ready low: fifth dropped
        for (int k = 0; k < 5; k++) send_bits($urandom, 32, 10, 0, 0, 0);
        idle(8, 1, 1);
        step(1, 1, 0, 0, 1, 1);
        // full FIFO with a pop in the exact completing cycle
        for (int k = 0; k < 4; k++) send_bits($urandom, 32, 0, 0, 0, 0);
        send_bits($urandom, 32, 0, 0, 1, 0);
        idle(8, 1, 1);
        // enable drop after 10 bits discards the partial word
        send_bits(32'hFFC00000, 10, 0, 1, 1, 0);
        idle(2, 0, 1);
        idle(1, 1, 1);
        send_bits(32'h12345678, 32, 0, 1, 1, 0);
        idle(3, 1, 1);
        // enable falling on the completing bit still pushes
        send_bits(32'hDEADBEEF, 31, 0, 1, 1, 0);
        step(1, 0, 1, 1, 1, 0);
        idle(3, 0, 1);
        idle(1, 1, 1);
        // reset mid-word with 2 buffered words and overflow set
        for (int k = 0; k < 5; k++) send_bits($urandom, 32, 0, 0, 0, 0);
        idle(2, 1, 1);
        send_bits($urandom, 12, 0, 0, 0, 0);
        step(0, 1, 1, 1, 0, 0);
        idle(2, 1, 0);
        // clear_ovf coinciding with a drop keeps overflow set
        for (int k = 0; k < 4; k++) send_bits($urandom, 32, 0, 0, 0, 0);
        send_bits($urandom, 32, 0, 0, 0, 1);
        idle(2, 1, 0);
        step(1, 1, 0, 0, 0, 1);
        idle(8, 1, 1);
        // random traffic
        for (int i = 0; i < 4000; i++)
            step(($urandom_range(0, 499) != 0), ($urandom_range(0, 99) < 95), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 3));
        idle(10, 1, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
